// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin message arbiter that shares the UART TX FIFO between NUM_REQ byte streams.
// Define UART_ARB_TIMEOUT_EN to drop a lock after TIMEOUT_CYC idle STALL cycles.
module uart_tx_arb #(
    parameter int          NUM_REQ     = 4,
    parameter logic [11:0] UDR_ADDR    = 12'h502,
    parameter logic [11:0] UCR_ADDR    = 12'h503,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic [11:0]          addr,
    output logic [31:0]          wrData,
    output logic                 wrEn,
    output logic                 rdEn,
    input  logic [31:0]          dataIn,
    input  logic                 inEn,
    output logic                 timeout
);
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, POLL, WAIT, STALL, WRITE} stateT;

    stateT         state;
    logic [PW-1:0] rrPtr, ownIdx, pickIdx, nextPtr, cand;
    logic          anyValid, ownValid, ownLast, goPoll, goWrite;
    logic [7:0]    ownByte;
    logic          unusedBits;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] stallCnt;
`else
    localparam int unusedTimeoutCyc = TIMEOUT_CYC;
    assign timeout = 1'b0;
`endif

    assign unusedBits = ^dataIn[31:1];
    assign anyValid   = |req_valid;
    assign ownValid   = req_valid[ownIdx];
    assign ownLast    = req_last[ownIdx];
    assign ownByte    = req_data[{ownIdx, 3'b000} +: 8];
    assign nextPtr    = (ownIdx == PW'(NUM_REQ - 1)) ? '0 : ownIdx + 1'b1;
    assign goWrite    = ownValid && ((state == WAIT && inEn && !dataIn[0]) || state == STALL);
    assign goPoll     = (state == IDLE && anyValid) || (state == WAIT && inEn && dataIn[0]) ||
                        (state == WRITE && !ownLast);

    // Round-robin pick: the valid requester closest at or after rrPtr wins (scanned far to near).
    always_comb begin
        pickIdx = rrPtr;
        cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(rrPtr) + k) % NUM_REQ);
            if (req_valid[cand]) pickIdx = cand;
        end
    end

    // Sequencer: arbitrate in IDLE, poll UCR before each byte, write UDR, hold the lock until last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rrPtr     <= '0;
            ownIdx    <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            rdEn      <= 1'b0;
            wrEn      <= 1'b0;
            addr      <= '0;
            wrData    <= '0;
            req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            stallCnt  <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            rdEn      <= goPoll;
            wrEn      <= goWrite;
            addr      <= goPoll ? UCR_ADDR : (goWrite ? UDR_ADDR : 12'h000);
            wrData    <= goWrite ? {24'b0, ownByte} : 32'b0;
            req_ready <= goWrite ? grant : '0;
`ifdef UART_ARB_TIMEOUT_EN
            stallCnt  <= '0;
            timeout   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (anyValid) begin
                        ownIdx <= pickIdx;
                        grant  <= NUM_REQ'(1) << pickIdx;
                        busy   <= 1'b1;
                        state  <= POLL;
                    end
                end
                POLL: state <= WAIT;
                WAIT: begin
                    if (inEn) state <= dataIn[0] ? POLL : (ownValid ? WRITE : STALL);
                end
                STALL: begin
`ifdef UART_ARB_TIMEOUT_EN
                    if (ownValid) state <= WRITE;
                    else if (stallCnt == CW'(TIMEOUT_CYC - 1)) begin
                        timeout <= 1'b1;
                        grant   <= '0;
                        busy    <= 1'b0;
                        rrPtr   <= nextPtr;
                        state   <= IDLE;
                    end else stallCnt <= stallCnt + 1'b1;
`else
                    if (ownValid) state <= WRITE;
`endif
                end
                WRITE: begin
                    if (ownLast) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        rrPtr <= nextPtr;
                        state <= IDLE;
                    end else state <= POLL;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb with a UART status model and a write scoreboard.
`timescale 1ns/1ps
module tb_uart_tx_arb;
    localparam int N = 4;
`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMO = 16;
`else
    localparam int TMO = 1024;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready, grant;
    logic           busy, wrEn, rdEn, timeout;
    logic           inEn = 1'b0;
    logic [11:0]    addr;
    logic [31:0]    wrData;
    logic [31:0]    dataIn = '0;

    uart_tx_arb #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant), .busy(busy), .addr(addr), .wrData(wrData),
        .wrEn(wrEn), .rdEn(rdEn), .dataIn(dataIn), .inEn(inEn), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [1:0] who; logic [7:0] b;} expT;
    typedef struct {int who; int n; logic [7:0] base; int full; int first; int last; int polls;} vecT;

    expT          expQ[$];
    logic [8:0]   msgQ[N][$];
    logic [N-1:0] hold = '0;
    int           fullCnt = 0, cyc = 0, rdCnt = 0, wrCnt = 0, tmoCnt = 0, tmoCyc = 0;
    int           wrAt[256];
    int           riseCyc[N];
    logic         busyAfterWr = 1'b0;
    logic [N-1:0] grantAfterWr = '0, grantAtTmo = '0;
    int           errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic enqueue(input int who, input int n, input logic [7:0] base);
        for (int j = 0; j < n; j++) msgQ[who].push_back({j == n - 1, base + 8'(j)});
    endtask

    task automatic expectMsg(input int who, input int n, input logic [7:0] base);
        for (int j = 0; j < n; j++) expQ.push_back(expT'({2'(who), base + 8'(j)}));
    endtask

    task automatic waitDone(input string name, input int budget);
        int k;
        k = 0;
        while ((expQ.size() != 0 || busy) && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
        tick();
    endtask

    task automatic chkReset();
        chk("rst_strobes", {28'b0, rdEn, wrEn, busy, timeout}, 32'd0);
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_wrData", wrData, 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
    endtask

    // Environment: bus monitor/scoreboard at negedge, requester and UART models just after posedge.
    initial begin : env
        logic [N-1:0] rdy;
        logic         rdSeen, prevWr;
        expT          e;
        prevWr = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            rdy    = req_ready;
            rdSeen = rdEn;
            if (prevWr) begin
                busyAfterWr  = busy;
                grantAfterWr = grant;
            end
            prevWr = wrEn;
            if (timeout) begin
                tmoCnt++;
                tmoCyc     = cyc;
                grantAtTmo = grant;
            end
            if (rdEn || wrEn) chk("strobe_excl", 32'(rdEn & wrEn), 32'd0);
            else chk("idle_bus", 32'(addr) | wrData, 32'd0);
            if (rdEn) begin
                rdCnt++;
                chk("poll_addr", 32'(addr), 32'h503);
            end
            if (wrEn) begin
                if (wrCnt < 256) wrAt[wrCnt] = cyc;
                wrCnt++;
                if (expQ.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_write: got data 0x%0h grant %b, want no write", wrData, grant);
                end else begin
                    e = expQ.pop_front();
                    chk("wr_data", wrData, {24'b0, e.b});
                    chk("wr_addr", 32'(addr), 32'h502);
                    chk("wr_ready", 32'(req_ready), 32'd1 << e.who);
                    chk("wr_grant", 32'(grant), 32'd1 << e.who);
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (rdy[i] && msgQ[i].size() > 0) void'(msgQ[i].pop_front());
                if (!req_valid[i] && msgQ[i].size() > 0 && !hold[i]) riseCyc[i] = cyc + 1;
                req_valid[i]      = msgQ[i].size() > 0 && !hold[i];
                req_data[8*i +: 8] = msgQ[i].size() > 0 ? msgQ[i][0][7:0] : 8'h00;
                req_last[i]       = msgQ[i].size() > 0 && msgQ[i][0][8];
            end
            inEn   = rdSeen;
            dataIn = {31'b0, rdSeen && fullCnt > 0};
            if (rdSeen && fullCnt > 0) fullCnt--;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200us");
        $fatal(1);
    end

    initial begin : main
        vecT vec[4];
        int  r0, w0, w1, k;
        vec[0] = '{0, 3, 8'h41, 0, 3, 9, 3};
        vec[1] = '{1, 1, 8'h55, 0, 3, 3, 1};
        vec[2] = '{3, 2, 8'hA0, 0, 3, 6, 2};
        vec[3] = '{2, 1, 8'h7E, 5, 13, 13, 6};
        repeat (3) tick();
        chkReset();
        rst = 1'b0;
        tick();
        for (int v = 0; v < 4; v++) begin
            r0 = rdCnt;
            w0 = wrCnt;
            fullCnt = vec[v].full;
            enqueue(vec[v].who, vec[v].n, vec[v].base);
            expectMsg(vec[v].who, vec[v].n, vec[v].base);
            waitDone("vec_done", 200);
            chk("vec_first_wr", 32'(wrAt[w0] - riseCyc[vec[v].who]), 32'(vec[v].first));
            chk("vec_last_wr", 32'(wrAt[w0 + vec[v].n - 1] - riseCyc[vec[v].who]), 32'(vec[v].last));
            chk("vec_polls", 32'(rdCnt - r0), 32'(vec[v].polls));
            chk("vec_writes", 32'(wrCnt - w0), 32'(vec[v].n));
            chk("vec_busy_after", 32'(busyAfterWr), 32'd0);
            chk("vec_grant_after", 32'(grantAfterWr), 32'd0);
        end

        rst = 1'b1;
        repeat (2) tick();
        chkReset();
        rst = 1'b0;
        w0 = wrCnt;
        enqueue(0, 2, 8'h10);
        enqueue(0, 2, 8'h30);
        enqueue(2, 2, 8'h20);
        expectMsg(0, 2, 8'h10);
        expectMsg(2, 2, 8'h20);
        expectMsg(0, 2, 8'h30);
        waitDone("arb_done", 300);
        chk("arb_writes", 32'(wrCnt - w0), 32'd6);

        w0 = wrCnt;
        enqueue(1, 2, 8'hC0);
        expectMsg(1, 2, 8'hC0);
        k = 0;
        while (wrCnt == w0 && k < 50) begin
            tick();
            k++;
        end
        chk("drop_first_wr", 32'(wrCnt - w0), 32'd1);
        hold[1] = 1'b1;
        repeat (3) tick();
        r0 = rdCnt;
        w1 = wrCnt;
        repeat (20) tick();
        chk("stall_no_rd", 32'(rdCnt - r0), 32'd0);
        chk("stall_no_wr", 32'(wrCnt - w1), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_grant", 32'(grant), 32'b0010);
        hold[1] = 1'b0;
        waitDone("drop_done", 50);
        chk("drop_resume", 32'(wrAt[w0 + 1] - riseCyc[1]), 32'd1);

        r0 = rdCnt;
        enqueue(0, 1, 8'h99);
        k = 0;
        while (rdCnt == r0 && k < 20) begin
            tick();
            k++;
        end
        chk("rw_poll_seen", 32'(rdCnt - r0), 32'd1);
        tick();
        chk("rw_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        msgQ[0].delete();
        tick();
        chkReset();
        rst = 1'b0;
        w0 = wrCnt;
        repeat (10) tick();
        chk("rw_no_wr", 32'(wrCnt - w0), 32'd0);
        chk("rw_idle", 32'(busy), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        w0 = wrCnt;
        r0 = tmoCnt;
        enqueue(1, 2, 8'hE0);
        expectMsg(1, 1, 8'hE0);
        k = 0;
        while (wrCnt == w0 && k < 50) begin
            tick();
            k++;
        end
        hold[1] = 1'b1;
        enqueue(3, 1, 8'h33);
        expectMsg(3, 1, 8'h33);
        k = 0;
        while (tmoCnt == r0 && k < 60) begin
            tick();
            k++;
        end
        chk("tmo_pulse", 32'(tmoCnt - r0), 32'd1);
        chk("tmo_delay", 32'(tmoCyc - wrAt[w0]), 32'd19);
        chk("tmo_grant", 32'(grantAtTmo), 32'd0);
        waitDone("tmo_next", 50);
        chk("tmo_single", 32'(tmoCnt - r0), 32'd1);
        msgQ[1].delete();
        hold[1] = 1'b0;
        repeat (3) tick();
`endif

        chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Message-level arbiter and sequencer that shares the memory-mapped `uart` peripheral's transmit path between `NUM_REQ` on-chip byte-stream requesters, such as the debug monitor, the boot loader echo and a trace port. It owns the UART bus port exclusively and drives it to the UART's UCR/UDR registers. It polls the TX-full flag before every byte and writes bytes into the TX FIFO. Grants are round-robin with a lock held from the first byte to the `last` byte, so messages never interleave.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `UDR_ADDR`, 12'h502: UART data register address.
- `UCR_ADDR`, 12'h503: UART control/status register address. Bit0 = TX FIFO full, bit1 = RX FIFO empty.
- `TIMEOUT_CYC`, 1024: idle cycles tolerated inside a locked message. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NUM_REQ  requester i has a byte on `req_data[8i+7:8i]`.
- `req_data`  in  8*NUM_REQ  byte per requester. Must be held stable while valid and not ready.
- `req_last`  in  NUM_REQ  the current byte ends requester i's message.
- `req_ready`  out  NUM_REQ  one-hot, one-cycle pulse: the byte is consumed this cycle.
- `grant`  out  NUM_REQ  one-hot lock owner. All zero when idle.
- `busy`  out  1  a message is in progress.
- `addr`  out  12  UART bus address.
- `wrData`  out  32  UART write data, `{24'b0, byte}`.
- `wrEn`  out  1  UART write strobe.
- `rdEn`  out  1  UART read strobe.
- `dataIn`  in  32  UART read data, valid when `inEn` is high.
- `inEn`  in  1  UART read-data valid. Arrives exactly one cycle after `rdEn`.
- `timeout`  out  1  one-cycle pulse when a lock is dropped by timeout. Tied to 0 without the macro.

## Operation
- FSM states: IDLE, POLL, WAIT, STALL, WRITE.
- IDLE:
  - When any `req_valid` is high, pick the first requester at or after the rotating pointer `rr_ptr` that has valid high.
  - Register `grant` and set `busy`, then go to POLL.
  - With no valid request, stay in IDLE.
- POLL:
  - Drive `rdEn`=1 and `addr`=UCR_ADDR for one cycle, then go to WAIT.
- WAIT:
  - Stay until `inEn` is high, then sample `dataIn[0]`.
  - If the bit is 1 (TX full), go back to POLL.
  - Otherwise, go to WRITE if `req_valid[grant]` is high, else go to STALL.
- STALL:
  - Wait for `req_valid[grant]`, then go to WRITE.
  - No re-poll is needed, because this block is the only TX writer and not-full cannot change.
- WRITE:
  - Drive `wrEn`=1, `addr`=UDR_ADDR, `wrData`={24'b0, granted byte} and `req_ready[grant]`=1 for one cycle.
  - If `req_last[grant]` is high: clear `grant` and `busy`, set `rr_ptr` = grant index + 1 (mod NUM_REQ), and go to IDLE.
  - Otherwise go to POLL.
- Arbitration happens only in IDLE. A request that arrives mid-message waits, whatever its position relative to `rr_ptr`.
- When `rdEn` and `wrEn` are both low, `addr` is 0 and `wrData` is 0. `rdEn` and `wrEn` are never high in the same cycle.
- `req_valid` dropping in POLL or WAIT has no effect until the WAIT decision is taken.

## Timing
- Reset values:
  - `rdEn`, `wrEn`, `addr`, `wrData`, `req_ready`, `grant`, `busy` and `timeout` are all 0.
  - `rr_ptr` is 0 and the state is IDLE.
- Reset mid-message abandons the message; no partial write is issued after reset.
- All bus outputs are registered.
- First byte of a message: IDLE detect at cycle t, `rdEn` at t+1, `inEn` at t+2, `wrEn`/`req_ready` at t+3.
- Steady-state throughput is 1 byte per 3 cycles (POLL, WAIT, WRITE) while the TX FIFO is not full.
- Back-to-back messages: IDLE adds 1 cycle between the last WRITE and the next POLL.
- UCR is registered inside the UART. A poll issued in the cycle after a write therefore reflects that write, and the POLL state guarantees this spacing.
- Single-byte message: `req_last` is high on the first byte, and `grant` clears the cycle after WRITE.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter counts consecutive cycles spent in STALL.
  - When the counter reaches `TIMEOUT_CYC`: pulse `timeout`, clear `grant` and `busy`, advance `rr_ptr` past the owner, and go to IDLE.
  - The counter clears on leaving STALL.
- `UART_ARB_TIMEOUT_EN` undefined:
  - STALL waits indefinitely, `timeout` is constant 0, and no counter logic is present.

## Test plan
- Reset, then requester 0 sends 3 bytes 0x41/0x42/0x43 with last on 0x43 and FIFO not full. Required: `wrEn` at cycles 3, 6 and 9 after valid, with `wrData` 0x41, 0x42, 0x43. `busy` is 0 one cycle after the third write.
- Requesters 0 and 2 valid together, each with 2-byte messages. Required: all of req0's message, then all of req2's, with no interleaving. Next round with 0 and 2 valid: req2 is served first because `rr_ptr` is 1.
- UCR returns bit0=1 for 5 polls, then 0. Required: 6 `rdEn` pulses, no `wrEn` until the 6th read result, then exactly one write.
- Requester 1 drops valid after its first non-last byte for 20 cycles. Required: the block stays in STALL with no bus strobes. The byte is written 1 cycle after valid returns.
- With the macro and `TIMEOUT_CYC`=16, the locked requester is silent. Required: `timeout` pulses after 16 STALL cycles, `grant` goes to 0, and a waiting requester 3 is granted next.
- Assert `rst` during WAIT. Required: all outputs 0 the next cycle and no `wrEn` afterwards until a new request arrives.
